// File: rtl/redundancy_ctrl_if.sv
// -----------------------------------------------------------------------------
// redundancy_ctrl_if
//   Groups the link/busy/manual-control inputs and the status outputs of
//   redundancy_ctrl into one bundle.
//
//   Signals
//     p1_link, p2_link   : link status of port 1 / port 2 (clk domain)
//     p1_busy, p2_busy   : tx_en|rx_dv of each port (foreign clock domain)
//     force_en, force_sel: manual mode enable and requested port (0 = p1)
//     sel                : mux select, 0 = port 1 active, 1 = port 2 active
//     state              : 0 ACTIVE, 1 DEBOUNCE, 2 DRAIN, 3 SWITCH
//     switch_pulse       : one-cycle pulse coincident with a sel toggle
//     switch_cnt         : saturating count of completed switches
//     no_link            : both links down (combinational)
//     drain_to           : sticky, a switch was forced by the drain timeout
//
//   Modports
//     master : the side that drives the link/busy/force inputs
//     slave  : the controller itself
// -----------------------------------------------------------------------------
interface redundancy_ctrl_if;
    logic       p1_link;
    logic       p2_link;
    logic       p1_busy;
    logic       p2_busy;
    logic       force_en;
    logic       force_sel;
    logic       sel;
    logic [1:0] state;
    logic       switch_pulse;
    logic [7:0] switch_cnt;
    logic       no_link;
    logic       drain_to;

    modport master (
        output p1_link, p2_link, p1_busy, p2_busy, force_en, force_sel,
        input  sel, state, switch_pulse, switch_cnt, no_link, drain_to
    );

    modport slave (
        input  p1_link, p2_link, p1_busy, p2_busy, force_en, force_sel,
        output sel, state, switch_pulse, switch_cnt, no_link, drain_to
    );
endinterface

// File: rtl/redundancy_ctrl.sv
// -----------------------------------------------------------------------------
// redundancy_ctrl
//   Two-port redundancy controller. Watches the link status of the active
//   port, debounces a loss, waits for both data paths to go idle (or for a
//   drain timeout) and then toggles the mux select. A manual mode lets the
//   user pick a port directly.
//
//   Ports
//     clk : system clock, the only clock of the block
//     rst : asynchronous, active-high reset
//     bus : redundancy_ctrl_if.slave (link/busy/force inputs, status outputs)
//
//   Parameters
//     HOLDOFF_CYCLES : cycles an active-link loss must persist before failover
//     IDLE_CYCLES    : consecutive idle cycles required before a switch
//     DRAIN_TIMEOUT  : maximum DRAIN residency before a forced switch
//     REVERT_CYCLES  : p1_link-high cycles before auto-revert to port 1
//
//   Build option
//     REDUN_REVERT_EN : when defined, the controller returns to port 1 once
//                       p1_link has been stable for REVERT_CYCLES; when not
//                       defined, port 2 stays selected until it fails or a
//                       manual request arrives.
// -----------------------------------------------------------------------------
module redundancy_ctrl #(
    parameter int HOLDOFF_CYCLES = 1250000,
    parameter int IDLE_CYCLES    = 16,
    parameter int DRAIN_TIMEOUT  = 125000,
    parameter int REVERT_CYCLES  = 125000000
) (
    input  logic             clk,
    input  logic             rst,
    redundancy_ctrl_if.slave bus
);

    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_ACTIVE   = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_SWITCH   = 2'd3
    } state_t;

    // Why DRAIN was entered; decides which conditions abort it.
    typedef enum logic [1:0] {
        CAUSE_AUTO   = 2'd0,
        CAUSE_MANUAL = 2'd1,
        CAUSE_REVERT = 2'd2
    } cause_t;

    state_t        r_state;
    cause_t        r_cause;
    logic          r_sel;
    logic          r_switch_pulse;
    logic [7:0]    r_switch_cnt;
    logic          r_drain_to;
    logic [HW-1:0] r_hold_cnt;
    logic [IW-1:0] r_idle_cnt;
    logic [TW-1:0] r_to_cnt;
    logic          r_p1_meta, r_p1_sync;
    logic          r_p2_meta, r_p2_sync;

    logic          w_act_link;
    logic          w_stby_link;
    logic          w_idle;
    logic          w_fail_cond;
    logic          w_force_req;
    logic          w_drain_abort;
    logic          w_revert_req;
    logic [IW-1:0] w_idle_next;
    logic [TW-1:0] w_to_next;

    assign w_act_link  = r_sel ? bus.p2_link : bus.p1_link;
    assign w_stby_link = r_sel ? bus.p1_link : bus.p2_link;
    assign w_idle      = ~(r_p1_sync | r_p2_sync);

    // Automatic failover only when the standby side can actually take over;
    // with both links down nothing starts.
    assign w_fail_cond = ~bus.force_en & ~w_act_link & w_stby_link;
    assign w_force_req = bus.force_en & (bus.force_sel != r_sel);

    // Saturating next values of the two DRAIN counters.
    assign w_idle_next = !w_idle ? '0 :
                         (r_idle_cnt >= IW'(IDLE_CYCLES)) ? r_idle_cnt : r_idle_cnt + IW'(1);
    assign w_to_next   = (r_to_cnt >= TW'(DRAIN_TIMEOUT)) ? r_to_cnt : r_to_cnt + TW'(1);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_drain_abort = 1'b0;
        case (r_cause)
            CAUSE_MANUAL: w_drain_abort = ~bus.force_en | (bus.force_sel == r_sel);
            CAUSE_REVERT: w_drain_abort = bus.force_en | ~bus.p1_link;
            default:      w_drain_abort = bus.force_en | w_act_link | ~w_stby_link;
        endcase
    end

`ifdef REDUN_REVERT_EN
    localparam int RW = $clog2(REVERT_CYCLES + 1);

    logic [RW-1:0] r_rev_cnt;
    logic          w_rev_cond;

    // Counts consecutive cycles with port 1 healthy while parked on port 2.
    assign w_rev_cond   = (r_state == ST_ACTIVE) & r_sel & ~bus.force_en & bus.p1_link;
    assign w_revert_req = w_rev_cond & (r_rev_cnt >= RW'(REVERT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rev_cnt <= '0;
        end else if (!w_rev_cond) begin
            r_rev_cnt <= '0;
        end else if (r_rev_cnt < RW'(REVERT_CYCLES)) begin
            r_rev_cnt <= r_rev_cnt + RW'(1);
        end
    end
`else
    logic w_unused_revert;

    // Keeps the revert parameter referenced when the revert logic is not built.
    assign w_unused_revert = (REVERT_CYCLES > 0);
    assign w_revert_req    = 1'b0;
`endif

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register sees the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_ACTIVE;
            r_cause        <= CAUSE_AUTO;
            r_sel          <= 1'b0;
            r_switch_pulse <= 1'b0;
            r_switch_cnt   <= '0;
            r_drain_to     <= 1'b0;
            r_hold_cnt     <= '0;
            r_idle_cnt     <= '0;
            r_to_cnt       <= '0;
            r_p1_meta      <= 1'b0;
            r_p1_sync      <= 1'b0;
            r_p2_meta      <= 1'b0;
            r_p2_sync      <= 1'b0;
        end else begin
            // Busy signals come from the PHY clock domains.
            r_p1_meta      <= bus.p1_busy;
            r_p1_sync      <= r_p1_meta;
            r_p2_meta      <= bus.p2_busy;
            r_p2_sync      <= r_p2_meta;
            r_switch_pulse <= 1'b0;

            case (r_state)
                ST_ACTIVE: begin
                    r_hold_cnt <= '0;
                    r_idle_cnt <= '0;
                    r_to_cnt   <= '0;
                    if (w_force_req) begin
                        r_state <= ST_DRAIN;
                        r_cause <= CAUSE_MANUAL;
                    end else if (w_fail_cond) begin
                        r_state <= ST_DEBOUNCE;
                    end else if (w_revert_req) begin
                        r_state <= ST_DRAIN;
                        r_cause <= CAUSE_REVERT;
                    end
                end

                ST_DEBOUNCE: begin
                    // Entered only with force_en low, so a high level here is a rise.
                    if (bus.force_en | w_act_link | ~w_stby_link) begin
                        r_state <= ST_ACTIVE;
                    end else if (r_hold_cnt >= HW'(HOLDOFF_CYCLES - 1)) begin
                        r_state <= ST_DRAIN;
                        r_cause <= CAUSE_AUTO;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                end

                ST_DRAIN: begin
                    r_idle_cnt <= w_idle_next;
                    r_to_cnt   <= w_to_next;
                    if (w_drain_abort) begin
                        r_state <= ST_ACTIVE;
                    end else if (w_idle_next >= IW'(IDLE_CYCLES)) begin
                        r_state <= ST_SWITCH;
                    end else if (w_to_next >= TW'(DRAIN_TIMEOUT)) begin
                        r_state    <= ST_SWITCH;
                        r_drain_to <= 1'b1;
                    end
                end

                ST_SWITCH: begin
                    r_sel          <= ~r_sel;
                    r_switch_pulse <= 1'b1;
                    if (r_switch_cnt != 8'hFF) begin
                        r_switch_cnt <= r_switch_cnt + 8'd1;
                    end
                    r_state <= ST_ACTIVE;
                end
            endcase
        end
    end

    assign bus.sel          = r_sel;
    assign bus.state        = r_state;
    assign bus.switch_pulse = r_switch_pulse;
    assign bus.switch_cnt   = r_switch_cnt;
    assign bus.drain_to     = r_drain_to;
    assign bus.no_link      = ~bus.p1_link & ~bus.p2_link;

endmodule
